// File: rtl/acc_rr_scheduler_if.sv
// Handshake bundle between the requesters and the round-robin accumulator scheduler.
// The requester side drives req/data, and the scheduler returns grant, status and the accumulator.
interface acc_rr_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] data_i;
  logic [N_REQ-1:0] gnt_o;
  logic             busy_o;
  logic             acc_o;
  logic             err_o;

  modport master (
    output req_i,
    output data_i,
    input  gnt_o,
    input  busy_o,
    input  acc_o,
    input  err_o
  );

  modport slave (
    input  req_i,
    input  data_i,
    output gnt_o,
    output busy_o,
    output acc_o,
    output err_o
  );
endinterface

// File: rtl/acc_rr_scheduler.sv
// Round-robin scheduler: grants one requester at a time for BURST cycles, and the
// owner's data bit is XOR-folded into a shared accumulator while it holds the grant.
//
//   state | meaning
//   IDLE  | arbitrating; a grant is issued on the first edge that sees any request
//   GRANT | owner holds gnt_o; accumulate each cycle, leave when count expires or req drops
//   GAP   | one dead cycle with gnt_o low before arbitrating again
module acc_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int BURST = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  acc_rr_scheduler_if.slave    bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = 4;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("acc_rr_scheduler: N_REQ must be within 2..8");
  end
  if (BURST < 1 || BURST > 15) begin : g_bad_burst
    $error("acc_rr_scheduler: BURST must be within 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      last_q, last_d;
  logic               acc_q, acc_d;
  (* tmrx_error_sink *)
  logic               err_q;
  logic               err_d;

  logic               any_req;
  logic               owner_req;
  logic               owner_data;
  logic [IW-1:0]      winner;

  assign any_req    = |bus.req_i;
  // last_q is updated when a grant issues, so it doubles as the owner index in GRANT
  assign owner_req  = bus.req_i[last_q];
  assign owner_data = bus.data_i[last_q];

  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    logic          found;
    winner = last_q;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IW'(idx);
      if (!found && bus.req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      acc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    acc_d   = acc_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (any_req) begin
          gnt_d[winner] = 1'b1;
          cnt_d         = CW'(BURST - 1);
          last_d        = winner;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // owner let go before its burst finished: no accumulate, flag it, release now
          err_d   = 1'b1;
          gnt_d   = '0;
          state_d = GAP;
        end else begin
          acc_d = acc_q ^ owner_data;
          if (cnt_q == '0) begin
            gnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      GAP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.gnt_o  = gnt_q;
    bus.busy_o = (state_q != IDLE);
    bus.acc_o  = acc_q;
    bus.err_o  = err_q;
  end

  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_q));
  a_gnt_only_in_grant : assert property (@(posedge clk_i) disable iff (rst_i)
                                         (state_q != GRANT) |-> (gnt_q == '0));

endmodule

// File: tb/tb_acc_rr_scheduler.sv
// Self-checking bench for acc_rr_scheduler (N_REQ=4, BURST=3): per-cycle vector table
// through a scoreboard queue, plus hand-written async-reset and priority sequences.
module tb_acc_rr_scheduler;

  localparam int N = 4;
  localparam int B = 3;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] data;
    logic [3:0] gnt;
    logic       busy;
    logic       acc;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_rr_scheduler_if #(.N_REQ(N)) bus ();

  acc_rr_scheduler #(.N_REQ(N), .BURST(B)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  vec_t vecs[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] d,
                              logic [3:0] g, logic b, logic a, logic e);
    vec_t v;
    v.rst = r; v.req = rq; v.data = d;
    v.gnt = g; v.busy = b; v.acc = a; v.err = e;
    return v;
  endfunction

  function automatic void add(logic r, logic [3:0] rq, logic [3:0] d,
                              logic [3:0] g, logic b, logic a, logic e);
    vecs.push_back(mk(r, rq, d, g, b, a, e));
  endfunction

  task automatic compare(string name, logic [6:0] act, logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: gnt/busy/acc/err got %b required %b", name, act, exp);
    end
  endtask

  task automatic sample(int id);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL vec%0d: scoreboard empty, got %b required an entry", id,
               {bus.gnt_o, bus.busy_o, bus.acc_o, bus.err_o});
    end else begin
      e = exp_q.pop_front();
      compare($sformatf("vec%0d", id), {bus.gnt_o, bus.busy_o, bus.acc_o, bus.err_o},
              {e.gnt, e.busy, e.acc, e.err});
    end
    checks++;
    if (!$onehot0(bus.gnt_o)) begin
      errors++;
      $display("FAIL onehot vec%0d: gnt got %b required at most one bit", id, bus.gnt_o);
    end
  endtask

  task automatic apply(vec_t v, int id);
    rst        = v.rst;
    bus.req_i  = v.req;
    bus.data_i = v.data;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    sample(id);
  endtask

  initial begin
    logic [3:0] d;
    logic [3:0] g;
    logic       a;

    bus.req_i  = '0;
    bus.data_i = '0;

    // reset held with all requests asserted
    add(1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0);
    // single requester 2: 3-cycle burst, 2-cycle gap, regrant; non-owner data ignored
    add(0, 4'b0100, 4'b0100, 4'b0100, 1, 0, 0);
    add(0, 4'b0100, 4'b0100, 4'b0100, 1, 1, 0);
    add(0, 4'b0100, 4'b0100, 4'b0100, 1, 0, 0);
    add(0, 4'b0100, 4'b0100, 4'b0000, 1, 1, 0);
    add(0, 4'b0100, 4'b0100, 4'b0000, 0, 1, 0);
    add(0, 4'b0100, 4'b0100, 4'b0100, 1, 1, 0);
    add(0, 4'b0100, 4'b1011, 4'b0100, 1, 1, 0);
    add(0, 4'b0100, 4'b0100, 4'b0100, 1, 0, 0);
    add(0, 4'b0100, 4'b0100, 4'b0000, 1, 1, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    // round robin with everyone requesting: order 0,1,2,3,0
    d = 4'b0101;
    a = 1'b0;
    for (int o = 0; o < N; o++) begin
      g = 4'b0001 << o;
      add(0, 4'b1111, d, g, 1, a, 0);
      for (int k = 0; k < B - 1; k++) begin
        a = a ^ d[o];
        add(0, 4'b1111, d, g, 1, a, 0);
      end
      a = a ^ d[o];
      add(0, 4'b1111, d, 4'b0000, 1, a, 0);
      add(0, 4'b1111, d, 4'b0000, 0, a, 0);
    end
    add(0, 4'b1111, d, 4'b0001, 1, a, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    // wrap-around from last=3: requester 0 then 3
    add(0, 4'b1001, 4'b0000, 4'b0001, 1, 0, 0);
    add(0, 4'b1001, 4'b0000, 4'b0001, 1, 0, 0);
    add(0, 4'b1001, 4'b0000, 4'b0001, 1, 0, 0);
    add(0, 4'b1001, 4'b0000, 4'b0000, 1, 0, 0);
    add(0, 4'b1001, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b1001, 4'b0000, 4'b1000, 1, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    // early drop by owner 1 in its second grant cycle; err sticky until reset
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 0, 0);
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0);
    add(0, 4'b0000, 4'b0010, 4'b0000, 1, 1, 1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1);
    add(0, 4'b0100, 4'b0000, 4'b0100, 1, 1, 1);
    add(0, 4'b0100, 4'b0000, 4'b0100, 1, 1, 1);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // reset pulse in cycle 2 of a grant must clear outputs without a clock edge
    apply(mk(0, 4'b0010, 4'b0010, 4'b0010, 1, 0, 0), 100);
    apply(mk(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0), 101);
    #2;
    rst = 1'b1;
    #1;
    compare("async_reset", {bus.gnt_o, bus.busy_o, bus.acc_o, bus.err_o}, 7'b0000000);
    apply(mk(1, 4'b0010, 4'b0010, 4'b0000, 0, 0, 0), 102);
    apply(mk(0, 4'b0010, 4'b0000, 4'b0010, 1, 0, 0), 103);
    apply(mk(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 0), 104);
    // after reset requester 0 has first priority
    apply(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0), 105);
    apply(mk(0, 4'b0011, 4'b0000, 4'b0001, 1, 0, 0), 106);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/acc_rr_scheduler.md
ACC_RR_SCHEDULER -- requirements
Module: acc_rr_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters; SHALL be in the range 2..8.
REQ-002 Parameter BURST, default 3, grant length in cycles; SHALL be in the range 1..15.
REQ-003 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous assertion, active-high.
REQ-005 req_i  input  N_REQ  per-requester request, level-sensitive.
REQ-006 data_i  input  N_REQ  per-requester data bit for the shared accumulator.
REQ-007 gnt_o  output  N_REQ  one-hot grant, registered.
REQ-008 busy_o  output  1  high while in GRANT or GAP.
REQ-009 acc_o  output  1  shared accumulator value (acc_q).
REQ-010 err_o  output  1  sticky protocol-error flag; SHALL carry the tmrx_error_sink attribute.

Function
REQ-011 FSM states SHALL be IDLE, GRANT and GAP.
REQ-012 IDLE: if any req_i bit is 1, select a winner, load gnt_o with the winner's one-hot code, load cnt = BURST-1 and go to GRANT on the next edge; otherwise stay in IDLE with gnt_o = 0.
REQ-013 Winner selection SHALL be round-robin: search upward from (last+1) mod N_REQ with wrap-around; the first requester with req_i = 1 wins.
REQ-014 last SHALL update to the winner index when the grant is issued.
REQ-015 GRANT, each cycle: acc_q <= acc_q ^ data_i[owner] when req_i[owner] = 1.
REQ-016 GRANT counter: cnt decrements each cycle; when cnt = 0, gnt_o clears and the FSM goes to GAP on that edge, after exactly BURST accumulate cycles.
REQ-017 GAP SHALL last exactly one cycle with gnt_o = 0, then return to IDLE; back-to-back owners are therefore separated by one idle cycle plus one arbitration cycle.
REQ-018 Request latency SHALL be 1 cycle: req_i sampled at edge k in IDLE gives gnt_o high after edge k.
REQ-019 Early drop: if req_i[owner] = 0 during GRANT, the cycle SHALL NOT accumulate, err_q SHALL set, and the FSM SHALL go to GAP immediately (gnt_o cleared on the same edge).
REQ-020 err_q SHALL be sticky and clear only on reset; err_o = err_q.
REQ-021 Requests arriving during GRANT or GAP SHALL be held by the requester and SHALL NOT be latched by the block.
REQ-022 gnt_o SHALL never have more than one bit set; it SHALL be 0 whenever the state is not GRANT.
REQ-023 busy_o = (state != IDLE), registered-state derived with no combinational path from req_i.
REQ-024 acc_o SHALL be driven directly from acc_q.

Reset
REQ-025 While rst_i = 1: state = IDLE, gnt_o = 0, cnt = 0, acc_q = 0, err_q = 0, last = N_REQ-1 (so requester 0 has first priority).
REQ-026 Asserting rst_i mid-GRANT SHALL clear all state asynchronously, without waiting for a clock edge; the first arbitration after release SHALL behave as from power-up.
REQ-027 Deassertion SHALL be treated as synchronous to clk_i by the integrator; the block adds no synchronizer.

Verification
REQ-028 Reset: assert rst_i with req_i = 4'b1111 -> gnt_o = 0, acc_o = 0, err_o = 0, busy_o = 0 while held.
REQ-029 Single requester (N_REQ = 4, BURST = 3): req_i = 4'b0100 held, data_i[2] = 1 -> gnt_o = 4'b0100 for 3 cycles, acc_o toggles 0->1->0->1, GAP 1 cycle, then regrant.
REQ-030 Round-robin: req_i = 4'b1111 from reset -> grant order 0, 1, 2, 3, 0, with gnt_o = 0 for 2 cycles between owners.
REQ-031 Wrap-around: last = 3 with req_i = 4'b1001 -> requester 0 wins; the next grant goes to 3.
REQ-032 Early drop: owner 1 drops req in its 2nd grant cycle -> 1 accumulate only, gnt_o = 0 next edge, err_o = 1 and stays 1 until rst_i.
REQ-033 Reset mid-burst: rst_i pulses in cycle 2 of GRANT -> gnt_o and acc_o go to 0 immediately; after release, req_i = 4'b0010 is granted to 1 after 1 cycle.
